// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: one 1-bit shift per clock through a row of
// shifting_mid select cells, sequenced by an IDLE/SHIFT/DONE controller.

module shifting_mid (
    input  logic sel_i,   // 0: take lower neighbour (left shift), 1: take upper neighbour
    input  logic lo_i,
    input  logic hi_i,
    output logic y_o
);
    assign y_o = sel_i ? hi_i : lo_i;
endmodule

module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic [AMT_W-1:0] count_q,  count_d;
    logic             dir_q,    dir_d;
    logic [1:0]       mode_q,   mode_d;

    logic             fill_left;
    logic             fill_right;
    logic             shift_out;
    logic [WIDTH-1:0] nbr_lo;
    logic [WIDTH-1:0] nbr_hi;
    logic [WIDTH-1:0] shifted;

    // Vacated-bit fill; rotate feeds back the bit leaving the opposite end.
    always_comb begin
        fill_left  = 1'b0;
        fill_right = 1'b0;
        if (mode_q == MODE_ROTATE) begin
            fill_left  = result_q[WIDTH-1];
            fill_right = result_q[0];
        end else if (mode_q == MODE_ARITH) begin
            fill_right = result_q[WIDTH-1];
        end
    end

    assign nbr_lo    = {result_q[WIDTH-2:0], fill_left};
    assign nbr_hi    = {fill_right, result_q[WIDTH-1:1]};
    assign shift_out = dir_q ? result_q[0] : result_q[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shifting_mid u_cell (
            .sel_i (dir_q),
            .lo_i  (nbr_lo[i]),
            .hi_i  (nbr_hi[i]),
            .y_o   (shifted[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        count_d  = count_q;
        dir_d    = dir_q;
        mode_d   = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = operand;
                    count_d  = amount;
                    dir_d    = dir;
                    mode_d   = mode;
                    carry_d  = 1'b0;
                    state_d  = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                result_d = shifted;
                carry_d  = shift_out;
                count_d  = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed operations push expected
// result/carry/completion cycle; a negedge monitor pops on every done pulse.

module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] operand;
    logic [3:0]  amount;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] result;
    logic        carry_out;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operand   (operand),
        .amount    (amount),
        .dir       (dir),
        .mode      (mode),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_carry", 32'(carry_out), 32'(e.c));
                check("sb_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic run_op(input logic [15:0] op, input logic [3:0] amt, input logic d,
                          input logic [1:0] m, input logic [15:0] exp_res, input logic exp_c,
                          input bit inject_shift, input bit inject_done);
        exp_t e;
        bit   seen = 0;
        @(negedge clk);
        operand = op; amount = amt; dir = d; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        e.res = exp_res; e.c = exp_c; e.due = cyc + int'(amt);
        sb.push_back(e);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < int'(amt) + 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                operand = ~op; amount = ~amt; dir = ~d; mode = m ^ 2'b01;
            end
            start = (inject_shift && i == 3) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done by cycle %0d", e.due);
            sb.delete();
        end
        if (inject_done) begin
            start = 1'b1; operand = 16'h5A5A; amount = 4'd2;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("hold_result", 32'(result), 32'(exp_res));
        check("hold_carry", 32'(carry_out), 32'(exp_c));
        check("stay_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; operand = '0; amount = '0; dir = 1'b0; mode = '0;
        operand = 16'hFFFF; amount = 4'd3; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", 32'(result), 32'h0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst = 1'b0;

        run_op(16'h8001, 4'd1,  1'b0, 2'b00, 16'h0002, 1'b1, 0, 0);
        run_op(16'hABCD, 4'd0,  1'b0, 2'b00, 16'hABCD, 1'b0, 0, 0);
        run_op(16'h8000, 4'd4,  1'b1, 2'b01, 16'hF800, 1'b0, 0, 1);
        run_op(16'h1234, 4'd4,  1'b0, 2'b10, 16'h2341, 1'b1, 0, 0);
        run_op(16'hFFFF, 4'd15, 1'b1, 2'b00, 16'h0001, 1'b1, 1, 0);
        run_op(16'hF00F, 4'd4,  1'b1, 2'b11, 16'h0F00, 1'b1, 0, 0);
        run_op(16'hC001, 4'd2,  1'b0, 2'b01, 16'h0004, 1'b1, 0, 0);
        run_op(16'h0001, 4'd1,  1'b1, 2'b10, 16'h8000, 1'b1, 0, 0);
        run_op(16'h4000, 4'd3,  1'b1, 2'b01, 16'h0800, 1'b0, 0, 0);
        run_op(16'h0003, 4'd15, 1'b0, 2'b00, 16'h8000, 1'b1, 0, 1);

        // Reset in the middle of a long shift: abandoned, no done afterwards.
        @(negedge clk);
        operand = 16'h00FF; amount = 4'd15; dir = 1'b1; mode = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_op_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_result", 32'(result), 32'h0);
        check("abort_carry", 32'(carry_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_quiet", 32'(busy), 32'd0);

        run_op(16'h00FF, 4'd3, 1'b1, 2'b00, 16'h001F, 1'b1, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
